// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ
// valid/ready requesters; each written word carries its source index.
module fifo_wr_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 4,
    parameter int  MAX_BURST  = 4,
    localparam int SRC_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [SRC_W-1:0]              fifo_write_src,
    output logic                          burst_active
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             fsm, fsm_next;
    logic [SRC_W-1:0]   owner, owner_next;
    logic [SRC_W-1:0]   last_grant, last_grant_next;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;

    logic [SRC_W-1:0]   cand;
    logic               cand_found;
    logic               xfer;
    logic               beat_last;

    // IDLE scans round-robin from the slot after the last grant; BURST locks to the owner.
    always_comb begin
        int idx;
        cand       = '0;
        cand_found = 1'b0;
        idx        = 0;
        if (fsm == BURST) begin
            cand       = owner;
            cand_found = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(last_grant) + 1 + i) % NUM_REQ;
                if (!cand_found && req_valid[idx]) begin
                    cand       = SRC_W'(idx);
                    cand_found = 1'b1;
                end
            end
        end
    end

    assign xfer      = rst_n && cand_found && req_valid[cand] && !fifo_full;
    assign beat_last = (int'(beat_cnt) + 1) == MAX_BURST;

    always_comb begin
        req_ready       = '0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;
        fifo_write_src  = '0;
        if (xfer) begin
            req_ready[cand] = 1'b1;
            fifo_write_en   = 1'b1;
            fifo_write_data = req_data[cand*DATA_WIDTH +: DATA_WIDTH];
            fifo_write_src  = cand;
        end
    end

    assign burst_active = rst_n && (fsm == BURST);

    always_comb begin
        fsm_next        = fsm;
        owner_next      = owner;
        last_grant_next = last_grant;
        beat_cnt_next   = beat_cnt;
        case (fsm)
            IDLE: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        last_grant_next = cand;
                    end else begin
                        fsm_next      = BURST;
                        owner_next    = cand;
                        beat_cnt_next = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                // A dropped owner releases the port at the cost of a one-cycle bubble.
                if (!req_valid[owner]) begin
                    fsm_next        = IDLE;
                    last_grant_next = owner;
                    beat_cnt_next   = '0;
                end else if (xfer) begin
                    if (beat_last) begin
                        fsm_next        = IDLE;
                        last_grant_next = owner;
                        beat_cnt_next   = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            owner      <= '0;
            last_grant <= SRC_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            fsm        <= fsm_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected (src, data) writes are queued
// as each scenario is set up and popped as the DUT writes.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 4;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_write_en;
    logic [DW-1:0]    fifo_write_data;
    logic [1:0]       fifo_write_src;
    logic             burst_active;

    logic [DW-1:0]    rdata    [NR];
    logic [DW-1:0]    exp_next [NR];
    int               q[$];
    int               nchk = 0;
    int               nerr = 0;

    logic             s_we, s_ba;
    logic [NR-1:0]    s_rdy;
    logic [1:0]       s_src;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .fifo_write_src  (fifo_write_src),
        .burst_active    (burst_active)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_data
        assign req_data[g*DW +: DW] = rdata[g];
    end

    task automatic check(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        rdata[i]    = v;
        exp_next[i] = v;
    endtask

    task automatic push_exp(input int src);
        q.push_back(src * 16 + int'(exp_next[src]));
        exp_next[src] = exp_next[src] + 1'b1;
    endtask

    // One clock: drive inputs, sample/score at negedge, advance sources on accept.
    task automatic step(input logic [NR-1:0] v, input logic f);
        logic [NR-1:0] acc;
        int e;
        req_valid = v;
        fifo_full = f;
        @(negedge clk);
        s_we  = fifo_write_en;
        s_ba  = burst_active;
        s_rdy = req_ready;
        s_src = fifo_write_src;
        acc   = req_ready & req_valid;
        if (fifo_write_en) begin
            check("no_write_when_full", int'(fifo_full), 0);
            check("ready_matches_src", int'(req_ready), 1 << fifo_write_src);
            if (q.size() == 0) begin
                check("sb_pending", q.size(), 1);
            end else begin
                e = q.pop_front();
                check("wr_src", int'(fifo_write_src), e / 16);
                check("wr_data", int'(fifo_write_data), e % 16);
            end
        end else begin
            check("no_write_ready_zero", int'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (acc[i]) rdata[i] = rdata[i] + 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) set_data(i, DW'(i * 4));

        // Reset with everyone valid, then release.
        repeat (3) begin
            step(4'b1111, 1'b0);
            check("rst_ready", int'(s_rdy), 0);
            check("rst_we", int'(s_we), 0);
        end
        rst_n = 1'b1;
        push_exp(0);
        step(4'b1111, 1'b0);
        check("rel_src", int'(s_src), 0);
        check("rel_ba", int'(s_ba), 0);
        step(4'b0000, 1'b0);
        check("ba_rise", int'(s_ba), 1);
        check("drop_we", int'(s_we), 0);

        // Single requester 2, data 1..9.
        set_data(2, 4'd1);
        for (int k = 1; k <= 9; k++) push_exp(2);
        for (int k = 1; k <= 9; k++) begin
            step(4'b0100, 1'b0);
            check("single_we", int'(s_we), 1);
            check("single_ba", int'(s_ba), (k == 1 || k == 5 || k == 9) ? 0 : 1);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Fairness from a fresh reset.
        rst_n = 1'b0;
        step(4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int b = 0; b < 20; b++) push_exp((b / 4) % 4);
        for (int b = 0; b < 20; b++) begin
            step(4'b1111, 1'b0);
            check("fair_we", int'(s_we), 1);
        end
        step(4'b0000, 1'b0);

        // Full stall mid-burst of requester 1 while requester 0 waits.
        push_exp(1); push_exp(1); push_exp(1); push_exp(1); push_exp(0);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        repeat (3) begin
            step(4'b0011, 1'b1);
            check("stall_we", int'(s_we), 0);
            check("stall_ready", int'(s_rdy), 0);
            check("stall_ba", int'(s_ba), 1);
        end
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0000, 1'b0);

        // Owner drop: bubble, then requester 3, then back to 0.
        push_exp(0); push_exp(0); push_exp(3); push_exp(0);
        step(4'b0001, 1'b0);
        step(4'b1001, 1'b0);
        step(4'b1000, 1'b0);
        check("drop0_bubble", int'(s_we), 0);
        step(4'b1000, 1'b0);
        check("drop_grant3", int'(s_src), 3);
        step(4'b0001, 1'b0);
        check("drop3_bubble", int'(s_we), 0);
        check("drop3_no_ready", int'(s_rdy), 0);
        step(4'b1001, 1'b0);
        check("after3_grant0", int'(s_src), 0);
        step(4'b0000, 1'b0);

        // Reset during beat 2 of requester 2.
        push_exp(2); push_exp(0); push_exp(0);
        step(4'b0100, 1'b0);
        rst_n = 1'b0;
        step(4'b1111, 1'b0);
        check("midrst_we", int'(s_we), 0);
        check("midrst_ready", int'(s_rdy), 0);
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        check("midrst_src0", int'(s_src), 0);
        check("midrst_ba_idle", int'(s_ba), 0);
        step(4'b1111, 1'b0);
        check("midrst_ba_burst", int'(s_ba), 1);
        step(4'b0000, 1'b0);

        check("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the synchronous FIFOs in this codebase. It shares one FIFO write port (write_en/write_data, gated by full) among NUM_REQ requesters, each on a valid/ready handshake. Grants are burst-locked: a winner keeps the port for up to MAX_BURST consecutive beats, then ownership rotates. Every written word is tagged with its source index.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 4: word width; matches the FIFO DATA_WIDTH.
- MAX_BURST, 4: maximum beats per grant, ≥1.
- SRC_W, derived: max(1, $clog2(NUM_REQ)).
- CNT_W, derived: $clog2(MAX_BURST+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; the word transfers when valid and ready are both high.
- fifo_full  in  1  FIFO full flag.
- fifo_write_en  out  1  FIFO write strobe.
- fifo_write_data  out  DATA_WIDTH  selected word.
- fifo_write_src  out  SRC_W  index of the requester being written.
- burst_active  out  1  high while in BURST.

## Operation
- State: fsm ∈ {IDLE, BURST}, owner[SRC_W], last_grant[SRC_W], beat_cnt[CNT_W].
- Reset (rst_n=0 at posedge):
  - fsm=IDLE, owner=0, last_grant=NUM_REQ-1, beat_cnt=0.
  - While rst_n=0, all outputs are forced to 0.
- Candidate selection:
  - IDLE: the first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - BURST: owner only.
- Transfer condition: the candidate exists, req_valid[cand]=1, and fifo_full=0. When it holds:
  - req_ready[cand]=1 and fifo_write_en=1.
  - fifo_write_data = the candidate's word; fifo_write_src = cand.
- Outputs with no transfer: req_ready=0, fifo_write_en=0, fifo_write_data=0, fifo_write_src=0.
- All outputs are combinational from registered state plus inputs (same-cycle handshake). There is no data path through registers.
- Transitions:
  - IDLE, transfer, MAX_BURST=1: stay IDLE, last_grant=cand.
  - IDLE, transfer, MAX_BURST>1: go to BURST, owner=cand, beat_cnt=1.
  - IDLE, no transfer (no valid, or fifo_full=1): hold all state. The pointer does not advance.
  - BURST, transfer, beat_cnt+1==MAX_BURST: go to IDLE, last_grant=owner, beat_cnt=0.
  - BURST, transfer, otherwise: beat_cnt+1.
  - BURST, req_valid[owner]=0: go to IDLE, last_grant=owner, beat_cnt=0. No transfer that cycle (one-cycle bubble by design).
  - BURST, req_valid[owner]=1 and fifo_full=1: stall and hold all state. Ownership is kept.
- Other requesters never receive ready while in BURST, regardless of their valid.
- last_grant wraps modulo NUM_REQ. beat_cnt never exceeds MAX_BURST-1 as a stored value.

## Timing
- Grant latency: 0 cycles. An eligible valid in IDLE transfers in the same cycle it is seen.
- Throughput: 1 word/cycle while fifo_full=0 and the owner stays valid. There is no bubble between consecutive bursts unless the owner drops valid mid-burst.
- Worst-case wait for a continuously valid requester with fifo_full=0: (NUM_REQ-1)*MAX_BURST cycles.
- fifo_full is sampled combinationally. A write is never issued in a cycle with fifo_full=1.
- Reset mid-burst: the next cycle after release is IDLE, and requester 0 has first priority.

## Test plan
Defaults: NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=4.
- Reset: rst_n=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0 and fifo_write_en=0 throughout. On the first cycle after release, fifo_write_src=0 and burst_active rises on the next edge.
- Single requester: only req 2 valid, data 1..9 on successive accepts, fifo_full=0 -> 9 back-to-back writes, data 1..9, src=2. burst_active drops for exactly one cycle after the 4th and 8th beats, with writes continuing through those cycles.
- Fairness: all 4 valid continuously with distinct data -> src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, one write per cycle.
- Full stall: req 1 owns the port after 2 beats; fifo_full=1 for 3 cycles while req 0 is also valid. Required:
  - 0 writes during the stall, req_ready=0, burst_active=1.
  - After the stall, beats 3 and 4 come from src=1, then req 0 is granted.
- Owner drop: req 0 drops valid after 2 beats while req 3 is valid -> one cycle with no write, then req 3 is granted (scan starts at 1). The next grant after req 3 goes to req 0 if valid.
- Reset mid-burst: assert rst_n=0 during beat 2 of req 2, with reqs 0–3 valid -> no write in the reset cycle. After release, src=0 is written first with beat_cnt restarting at 1.
